// File: rtl/ysyx_23060111_pkg.sv
// ysyx_23060111_pkg: opcode constants, immediate-type encoding and ebreak word for the decode stage
package ysyx_23060111_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] EBREAK_INST = 32'h00100073;
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;
endpackage

// File: rtl/ysyx_23060111_imm_gen.sv
// ysyx_23060111_imm_gen: combinational immediate decoder, inst -> sign-extended imm, imm_type, inv_flag
//   i_inst       instruction word
//   o_imm        XLEN-wide sign-extended immediate (0 for R/system/unknown)
//   o_imm_type   NONE/I/S/B/U/J
//   o_inv_flag   opcode not recognised
module ysyx_23060111_imm_gen
  import ysyx_23060111_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_inst,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_imm_type,
  output logic            o_inv_flag
);
  logic [6:0]  w_op;
  imm_type_e   w_type;
  logic [31:0] w_imm32;
  assign w_op = i_inst[6:0];
  assign w_type = (w_op == OP_LUI || w_op == OP_AUIPC) ? IMM_U :
                  (w_op == OP_JAL) ? IMM_J :
                  (w_op == OP_IMM || w_op == OP_JALR || w_op == OP_LOAD) ? IMM_I :
                  (w_op == OP_STORE) ? IMM_S :
                  (w_op == OP_BRANCH) ? IMM_B : IMM_NONE;
  assign o_inv_flag = (w_type == IMM_NONE) && !(w_op == OP_REG || w_op == OP_SYSTEM);
  assign w_imm32 = (w_type == IMM_U) ? {i_inst[31:12], 12'b0} :
                   (w_type == IMM_J) ? {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0} :
                   (w_type == IMM_I) ? {{20{i_inst[31]}}, i_inst[31:20]} :
                   (w_type == IMM_S) ? {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]} :
                   (w_type == IMM_B) ? {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0} :
                   32'b0;
  // every 32-bit form already carries its sign in bit 31, so widening to XLEN is a plain sign extension
  assign o_imm = XLEN'($signed(w_imm32));
  assign o_imm_type = w_type;
endmodule

// File: rtl/ysyx_23060111_idu_stage.sv
// ysyx_23060111_idu_stage: pipelined RV32/RV64 decode stage with a DEPTH-entry registered output queue
//   in_valid/in_ready/in_inst/in_pc   IFU side handshake
//   out_valid/out_ready/out_pc/...    EXU side, head entry of the queue (registered)
//   flush                             drops queue contents and the current input
module ysyx_23060111_idu_stage
  import ysyx_23060111_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NR_REG = 32,
  parameter int DEPTH  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type,
  output logic            inv_flag,
  output logic            reg_fault,
  output logic            is_ebreak
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 2 * XLEN + 37;
  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_imm_type;
  logic            w_inv, w_fault, w_use_rd, w_use_rs1, w_use_rs2;
  logic            w_push, w_pop, w_load, w_from_in;
  logic [EW-1:0]   w_entry;
  logic [EW-1:0]   r_q [DEPTH];
  logic [EW-1:0]   r_head;
  logic [31:0]     w_out_inst;
  logic [AW-1:0]   r_rd, r_wr, w_rd_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  ysyx_23060111_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_inst     (in_inst),
    .o_imm      (w_imm),
    .o_imm_type (w_imm_type),
    .o_inv_flag (w_inv)
  );
  assign w_use_rd  = w_imm_type == IMM_U || w_imm_type == IMM_J || w_imm_type == IMM_I || in_inst[6:0] == OP_REG;
  assign w_use_rs1 = w_imm_type == IMM_I || w_imm_type == IMM_S || w_imm_type == IMM_B || in_inst[6:0] == OP_REG;
  assign w_use_rs2 = w_imm_type == IMM_S || w_imm_type == IMM_B || in_inst[6:0] == OP_REG;
  // with 16 registers any used index with bit 4 set is outside the register file
  assign w_fault = (NR_REG == 16) && !w_inv &&
                   ((w_use_rd && in_inst[11]) || (w_use_rs1 && in_inst[19]) || (w_use_rs2 && in_inst[24]));
  assign w_entry   = {in_pc, in_inst, w_imm, w_imm_type, w_inv, w_fault};
  assign in_ready  = (r_cnt < CW'(DEPTH)) && !rst;
  assign out_valid = r_cnt != '0;
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;
  assign w_rd_n    = w_pop ? inc(r_rd) : r_rd;
  assign w_cnt_n   = r_cnt + CW'(w_push) - CW'(w_pop);
  // head register reloads when the head changes and something remains; otherwise it holds its last value
  assign w_load    = (w_pop || r_cnt == '0) && w_cnt_n != '0;
  // the queue is empty once the pop is taken, so the incoming entry becomes the head directly
  assign w_from_in = r_cnt == CW'(w_pop);
  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wr] <= w_entry;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      r_head <= '0;
    end else if (flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= inc(r_wr);
      r_rd  <= w_rd_n;
      r_cnt <= w_cnt_n;
      if (w_load) r_head <= w_from_in ? w_entry : r_q[w_rd_n];
    end
  end
  assign out_pc     = r_head[EW-1 -: XLEN];
  assign w_out_inst = r_head[XLEN+36 -: 32];
  assign imm        = r_head[XLEN+4 -: XLEN];
  assign imm_type   = r_head[4:2];
  assign inv_flag   = r_head[1];
  assign reg_fault  = r_head[0];
  assign opcode     = w_out_inst[6:0];
  assign rd         = w_out_inst[11:7];
  assign funct3     = w_out_inst[14:12];
  assign rs1        = w_out_inst[19:15];
  assign rs2        = w_out_inst[24:20];
  assign funct7     = w_out_inst[31:25];
  assign is_ebreak  = w_out_inst == EBREAK_INST;
endmodule

// File: tb/tb_ysyx_23060111_idu_stage.sv
// tb_ysyx_23060111_idu_stage: directed checks of the decode stage (RV32/32 regs and RV64/16 regs side by side)
module tb_ysyx_23060111_idu_stage;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_inst = '0, in_pc = '0;
  logic [63:0] in_pc64;
  logic in_ready, out_valid, inv_flag, reg_fault, is_ebreak;
  logic [31:0] out_pc, imm;
  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3, imm_type;
  logic r64_in_ready, r64_out_valid, r64_inv, r64_fault, r64_ebreak;
  logic [63:0] r64_pc, r64_imm;
  logic [6:0] r64_opcode, r64_funct7;
  logic [4:0] r64_rd, r64_rs1, r64_rs2;
  logic [2:0] r64_funct3, r64_type;
  int errors = 0, checks = 0;
  assign in_pc64 = {32'h0, in_pc};
  always #5 clk = ~clk;
  ysyx_23060111_idu_stage u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .imm_type(imm_type), .inv_flag(inv_flag),
    .reg_fault(reg_fault), .is_ebreak(is_ebreak)
  );
  ysyx_23060111_idu_stage #(.XLEN(64), .NR_REG(16), .DEPTH(2)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r64_in_ready),
    .in_inst(in_inst), .in_pc(in_pc64), .out_valid(r64_out_valid), .out_ready(out_ready),
    .out_pc(r64_pc), .opcode(r64_opcode), .rd(r64_rd), .funct3(r64_funct3), .rs1(r64_rs1),
    .rs2(r64_rs2), .funct7(r64_funct7), .imm(r64_imm), .imm_type(r64_type), .inv_flag(r64_inv),
    .reg_fault(r64_fault), .is_ebreak(r64_ebreak)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1;
    in_inst = inst;
    in_pc = pc;
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_imm", imm, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_opcode", opcode, 0);
    rst = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    out_ready = 1;
    drive(32'hfff00093, 32'h80000000);
    tick();
    chk("addi_valid", out_valid, 1);
    chk("addi_rd", rd, 1);
    chk("addi_imm", imm, 32'hffffffff);
    chk("addi_type", imm_type, 1);
    chk("addi_inv", inv_flag, 0);
    chk("addi_pc", out_pc, 32'h80000000);
    chk("addi_imm64", r64_imm, 64'hffffffffffffffff);
    chk("addi_fault64", r64_fault, 0);
    drive(32'hfe000ee3, 32'h80000004);
    tick();
    chk("beq_imm", imm, 32'hfffffffc);
    chk("beq_type", imm_type, 3);
    chk("beq_pc", out_pc, 32'h80000004);
    chk("beq_in_ready", in_ready, 1);
    drive(32'h008000ef, 32'h80000008);
    tick();
    chk("jal_imm", imm, 32'h00000008);
    chk("jal_type", imm_type, 5);
    chk("jal_rd", rd, 1);
    drive(32'h123452b7, 32'h8000000c);
    tick();
    chk("lui_imm", imm, 32'h12345000);
    chk("lui_type", imm_type, 4);
    chk("lui_rd", rd, 5);
    chk("lui_imm64", r64_imm, 64'h0000000012345000);
    drive(32'h0000007f, 32'h80000010);
    tick();
    chk("bad_inv", inv_flag, 1);
    chk("bad_imm", imm, 0);
    chk("bad_type", imm_type, 0);
    chk("bad_ebreak", is_ebreak, 0);
    drive(32'h00100073, 32'h80000014);
    tick();
    chk("ebreak_flag", is_ebreak, 1);
    chk("ebreak_inv", inv_flag, 0);
    chk("ebreak_type", imm_type, 0);
    chk("ebreak_imm", imm, 0);
    drive(32'h00100893, 32'h80000018);
    tick();
    chk("x17_rd", rd, 17);
    chk("x17_imm", imm, 1);
    chk("x17_fault32", reg_fault, 0);
    chk("x17_fault16", r64_fault, 1);
    in_valid = 0;
    tick();
    chk("drain_valid", out_valid, 0);
    chk("drain_hold_imm", imm, 1);
    out_ready = 0;
    drive(32'h00100093, 32'h00000100);
    tick();
    chk("bp1_in_ready", in_ready, 1);
    drive(32'h00200113, 32'h00000104);
    tick();
    chk("bp2_in_ready", in_ready, 0);
    chk("bp2_valid", out_valid, 1);
    chk("bp2_imm", imm, 1);
    chk("bp2_pc", out_pc, 32'h100);
    drive(32'h00300193, 32'h00000108);
    tick();
    tick();
    chk("bp4_in_ready", in_ready, 0);
    chk("bp4_imm_stable", imm, 1);
    out_ready = 1;
    #1;
    chk("no_bypass", in_ready, 0);
    tick();
    chk("pop1_imm", imm, 2);
    chk("pop1_pc", out_pc, 32'h104);
    chk("pop1_in_ready", in_ready, 1);
    chk("pop1_valid", out_valid, 1);
    out_ready = 0;
    tick();
    chk("refill_head", imm, 2);
    chk("refill_in_ready", in_ready, 0);
    flush = 1;
    out_ready = 1;
    drive(32'h00400213, 32'h0000010c);
    tick();
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_hold_imm", imm, 2);
    flush = 0;
    in_valid = 0;
    tick();
    chk("flush_after_valid", out_valid, 0);
    out_ready = 0;
    drive(32'h00500293, 32'h00000110);
    tick();
    chk("pre_flush2_imm", imm, 5);
    flush = 1;
    drive(32'h00600313, 32'h00000114);
    tick();
    flush = 0;
    in_valid = 0;
    chk("flush2_valid", out_valid, 0);
    tick();
    chk("flush2_dropped", out_valid, 0);
    drive(32'h00700393, 32'h00000200);
    tick();
    in_valid = 0;
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_imm", imm, 7);
    chk("post_flush_pc", out_pc, 32'h200);
    chk("post_flush_rd", rd, 7);
    rst = 1;
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_imm", imm, 0);
    chk("mid_rst_pc", out_pc, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    rst = 0;
    #1;
    chk("mid_rst_release", in_ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ysyx_23060111_idu_stage.md
# ysyx_23060111_idu_stage

Pipelined, parametrised RV32/RV64 instruction decode stage between IFU and EXU. It accepts fetched instructions over a valid/ready handshake and decodes fields, immediate, immediate type, invalid and ebreak flags. Results are held in a DEPTH-entry output queue with one-cycle latency. Supports flush, register-file size checking (RV32E/RV32I) and XLEN-wide immediate sign extension; ebreak is reported as a flag, not through a DPI call.

## Interface
Parameters:
- XLEN, 32, datapath width (32 or 64); imm and pc are XLEN wide.
- NR_REG, 32, architectural registers (16 or 32); indices ≥ NR_REG raise reg_fault.
- DEPTH, 2, output queue entries (1..4).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  drop all queued entries and the current input.
- in_valid  in  1  IFU has an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  head entry valid.
- out_ready  in  1  EXU consumes head.
- out_pc  out  XLEN  pc of head.
- opcode / rd / funct3 / rs1 / rs2 / funct7  out  7/5/3/5/5/7  raw fields of head.
- imm  out  XLEN  sign-extended immediate.
- imm_type  out  3  NONE=0, I=1, S=2, B=3, U=4, J=5.
- inv_flag  out  1  opcode not recognised.
- reg_fault  out  1  used register index ≥ NR_REG.
- is_ebreak  out  1  inst == 0x00100073.

## Operation
- Decode is combinational on in_inst; the result plus in_pc is pushed into the queue on accept (in_valid && in_ready && !flush).
- Opcode map: 0010111 auipc, 0110111 lui → U, imm = {inst[31:12],12'b0} sign-extended. 1101111 jal → J, {inst[31],inst[19:12],inst[20],inst[30:21],0}. 0010011, 1100111, 0000011 → I, inst[31:20]. 0100011 → S, {inst[31:25],inst[11:7]}. 1100011 → B, {inst[31],inst[7],inst[30:25],inst[11:8],0}. 0110011 → NONE, imm 0. 1110011 → NONE, imm 0. Any other opcode: imm 0, imm_type NONE, inv_flag 1.
- All immediates are sign-extended from their top bit to XLEN.
- reg_fault, only when NR_REG=16: set if bit 4 is set in any field the type uses (rd: U/J/I/R; rs1: I/S/B/R; rs2: S/B/R). Always 0 when NR_REG=32. inv_flag entries never raise reg_fault.
- Queue: circular buffer, rd/wr pointers wrap modulo DEPTH, count 0..DEPTH. in_ready = (count < DEPTH) && !rst. No combinational bypass from out_ready to in_ready.
- Simultaneous push and pop when full is impossible (in_ready=0). When 0 < count < DEPTH, push and pop in the same cycle leave count unchanged.
- flush: next cycle count = 0, out_valid = 0. A pop and push in the flush cycle are both discarded. Flush has priority over the handshake.

## Timing
- Reset: count=0, pointers=0, out_valid=0, all data outputs 0, in_ready=0 while rst is high and 1 on the first cycle after.
- Latency: an instruction accepted at edge N appears at out_valid/out_* after edge N (visible in cycle N+1).
- Throughput: 1 instr/cycle while out_ready=1 continuously.
- Output data is stable while out_valid && !out_ready. Outputs are registered from queue storage, with no combinational path from in_* to out_*.
- Empty head: data outputs hold their last value; only out_valid is meaningful.
- rst mid-operation: queue contents are lost; same state as power-on reset.

## Structure
- Package ysyx_23060111_pkg: opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_REG, OP_SYSTEM), imm_type encoding, EBREAK_INST.
- Sub-module ysyx_23060111_imm_gen: purely combinational, inst → {imm, imm_type, inv_flag}, parametrised by XLEN. Queue and reg_fault logic stay in the top.

## Test plan
- XLEN=32: push 0xfff00093 (addi x1,x0,-1) → next cycle out_valid=1, rd=1, imm=0xffffffff, imm_type=I, inv_flag=0.
- Push 0xfe000ee3 (beq -4), 0x008000ef (jal x1,8) and 0x123452b7 (lui x5) back-to-back with out_ready=1. Required: imm 0xfffffffc/B, 0x00000008/J and 0x12345000/U on consecutive cycles.
- Push 0x0000007f → inv_flag=1, imm=0, imm_type=NONE. Push 0x00100073 → is_ebreak=1, inv_flag=0.
- DEPTH=2, out_ready=0, in_valid=1 for 4 cycles → two accepts, then in_ready=0. Raise out_ready → first-accepted entry pops first, and in_ready returns the cycle after the first pop.
- Two entries queued, assert flush with in_valid=1 → next cycle out_valid=0, count 0, and the flushed-cycle input never appears.
- NR_REG=16: push addi x17,x0,1 (0x00100893) → reg_fault=1. XLEN=64: same addi -1 → imm=0xffffffffffffffff.
